div_32_23_seq: RTL



---
 rtl/div_32_23_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/div_32_23_seq.sv
// Sequential divide-by-23: 32-bit dividend, DIGIT_BITS per cycle, 28-bit quotient and 5-bit remainder.
// Optional build macro DIV23_SELFCHECK_EN adds a sticky err output that rechecks q*23+r.
module div_32_23_seq #(
    parameter int DIGIT_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [27:0] out_q,
    output logic [4:0]  out_r,
    output logic        busy
`ifdef DIV23_SELFCHECK_EN
    ,
    output logic        err
`endif
);

    localparam int N  = 32 / DIGIT_BITS;
    localparam int TW = 5 + DIGIT_BITS;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q;
    logic [31:0]           sh_q;
    logic [4:0]            rem_q;
    logic [5:0]            cnt_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic [27:0]           out_q_q;
    logic [4:0]            out_r_q;

    logic [TW-1:0]         t_d;
    logic [TW-1:0]         sub_d;
    logic [DIGIT_BITS-1:0] dig_d;
    logic [4:0]            rem_d;

    // Comparison ladder picks the largest multiple of 23 not above t.
    always_comb begin
        t_d   = {rem_q, sh_q[31 -: DIGIT_BITS]};
        dig_d = '0;
        sub_d = '0;
        for (int k = 1; k < (1 << DIGIT_BITS); k++) begin
            if (t_d >= TW'(23 * k)) begin
                dig_d = DIGIT_BITS'(k);
                sub_d = TW'(23 * k);
            end
        end
        rem_d = 5'(t_d - sub_d);
    end

    // Quotient digits shift into the low end of the dividend register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_q_q     <= '0;
            out_r_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        sh_q       <= in_x;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    sh_q  <= {sh_q[31-DIGIT_BITS:0], dig_d};
                    rem_q <= rem_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(N - 1)) begin
                        out_q_q     <= {sh_q[27-DIGIT_BITS:0], dig_d};
                        out_r_q     <= rem_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_q     = out_q_q;
    assign out_r     = out_r_q;
    assign busy      = busy_q;

`ifdef DIV23_SELFCHECK_EN
    logic [31:0] opnd_q;
    logic        err_q;
    logic [36:0] chk_d;

    assign chk_d = {9'd0, out_q_q} * 37'd23 + {32'd0, out_r_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opnd_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid)
                opnd_q <= in_x;
            if (state_q == DONE &&
                (chk_d != {5'd0, opnd_q} || out_r_q > 5'd22))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule
